// File: rtl/hs_mem_pkg.sv
// Shared types and LFSR helper for the parametrised handshake memory.
package hs_mem_pkg;

    typedef enum logic [1:0] {StIdle, StWait, StAck, StAbort} state_t;

    // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR land on bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] next_lfsr(input logic [15:0] cur);
        return {^(cur & LFSR_TAPS), cur[15:1]};
    endfunction

endpackage

// File: rtl/hs_mem_param_lat_gen.sv
// Access-latency generator: fixed MAX_LAT, or an LFSR value folded into [MIN_LAT, MAX_LAT].
module lat_gen
    import hs_mem_pkg::*;
#(
    parameter int unsigned MIN_LAT  = 1,
    parameter int unsigned MAX_LAT  = 10,
    parameter int unsigned RAND_LAT = 1,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    output logic [3:0] lat
);

    localparam int unsigned SPAN = MAX_LAT - MIN_LAT + 1;

    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else if (step) begin
            lfsr_q <= next_lfsr(lfsr_q);
        end
    end

    // lat reflects the pre-step value, so it is valid in the same cycle step is raised.
    always_comb begin
        if (RAND_LAT != 0) begin
            lat = 4'(MIN_LAT + (32'(lfsr_q) % SPAN));
        end else begin
            lat = 4'(MAX_LAT);
        end
    end

endmodule

// File: rtl/hs_mem_param.sv
// Single-port request/ack memory with variable latency, byte-enabled writes and abort pulses.
module hs_mem_param
    import hs_mem_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned MIN_LAT  = 1,
    parameter int unsigned MAX_LAT  = 10,
    parameter int unsigned RAND_LAT = 1,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     data_i,
    input  logic [DATA_W/8-1:0]   be,
    output logic [DATA_W-1:0]     data_o,
    output logic                  ack,
    output logic                  abort
);

    localparam int unsigned NUM_BYTES = DATA_W / 8;
    localparam int unsigned DEPTH     = 2 ** ADDR_W;

    if ((DATA_W % 8) != 0 || DATA_W == 0) begin : g_bad_data_w
        $error("hs_mem_param: DATA_W must be a non-zero multiple of 8");
    end
    if (MIN_LAT > MAX_LAT || MAX_LAT > 15) begin : g_bad_lat
        $error("hs_mem_param: need MIN_LAT <= MAX_LAT <= 15");
    end
    if (SEED == 16'h0000) begin : g_bad_seed
        $error("hs_mem_param: SEED must be non-zero");
    end

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   accept;
    logic                   op_write_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [NUM_BYTES-1:0]   be_q;
    logic                   req_stable;
    logic [3:0]             lat;
    logic [DATA_W-1:0]      mem [DEPTH];

    lat_gen #(
        .MIN_LAT  (MIN_LAT),
        .MAX_LAT  (MAX_LAT),
        .RAND_LAT (RAND_LAT),
        .SEED     (SEED)
    ) u_lat_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (accept),
        .lat   (lat)
    );

    // The bus must hold exactly the request it launched for the whole wait.
    always_comb begin
        if (op_write_q) begin
            req_stable = write && !read && (addr == addr_q) && (data_i == wdata_q) && (be == be_q);
        end else begin
            req_stable = read && !write && (addr == addr_q);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (read && write) begin
                    state_d = StAbort;
                end else if (read ^ write) begin
                    accept  = 1'b1;
                    cnt_d   = lat;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (!req_stable) begin
                    state_d = StAbort;
                end else if (cnt_q == 4'd0) begin
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAck, StAbort: state_d = StIdle;
            default:        state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_write_q <= write;
                addr_q     <= addr;
                wdata_q    <= data_i;
                be_q       <= be;
            end
        end
    end

    // Storage is deliberately not reset; a reset ahead of ACK leaves it untouched.
    always_ff @(posedge clk) begin
        if (state_q == StAck && op_write_q) begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (be_q[k]) begin
                    mem[addr_q][8*k +: 8] <= wdata_q[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        ack    = (state_q == StAck);
        abort  = (state_q == StAbort);
        data_o = (ack && !op_write_q) ? mem[addr_q] : '0;
    end

endmodule

// File: tb/tb_hs_mem_param.sv
// Randomised and directed checks of hs_mem_param against a transaction-level model.
module tb_hs_mem_param;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NB   = DW / 8;
    localparam int MINL = 1;
    localparam int MAXL = 10;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: 32-bit, random latency
    logic          rst_n = 1'b1;
    logic          read, write;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_i, data_o;
    logic [NB-1:0] be;
    logic          ack, abort;

    hs_mem_param #(
        .DATA_W(DW), .ADDR_W(AW), .MIN_LAT(MINL), .MAX_LAT(MAXL), .RAND_LAT(1), .SEED(SEED)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr), .data_i(data_i),
        .be(be), .data_o(data_o), .ack(ack), .abort(abort)
    );

    // Second instance: 8-bit, fixed latency 3
    logic       rst_nf = 1'b1;
    logic       read_f, write_f;
    logic [4:0] addr_f;
    logic [7:0] data_if, data_of;
    logic [0:0] be_f;
    logic       ack_f, abort_f;

    hs_mem_param #(
        .DATA_W(8), .ADDR_W(5), .MIN_LAT(0), .MAX_LAT(3), .RAND_LAT(0), .SEED(SEED)
    ) u_fix (
        .clk(clk), .rst_n(rst_nf), .read(read_f), .write(write_f), .addr(addr_f),
        .data_i(data_if), .be(be_f), .data_o(data_of), .ack(ack_f), .abort(abort_f)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic [DW-1:0] m_mem   [1<<AW];
    logic [NB-1:0] m_known [1<<AW] = '{default: '0};
    logic [15:0]   m_lfsr  = SEED;
    int            cyc     = 0;
    int            ack_at  = -1;
    int            abort_at = -1;
    bit            busy    = 1'b0;
    bit            t_write = 1'b0;
    logic [AW-1:0] t_addr  = '0;
    logic [DW-1:0] t_data  = '0;
    logic [NB-1:0] t_be    = '0;
    bit            chk_on  = 1'b0;
    logic [DW-1:0] cmp_mask;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    function automatic bit held_ok();
        if (t_write) return write && !read && addr == t_addr && data_i == t_data && be == t_be;
        return read && !write && addr == t_addr;
    endfunction

    // A transaction accepted at edge c acks at edge c+L+1; the edge after ack/abort is dead.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     = 1'b0;
            ack_at   = -1;
            abort_at = -1;
            m_lfsr   = SEED;
        end else begin
            cyc++;
            if (cyc - 1 == ack_at || cyc - 1 == abort_at) begin
                if (cyc - 1 == ack_at && t_write) begin
                    for (int k = 0; k < NB; k++) begin
                        if (t_be[k]) begin
                            m_mem[t_addr][8*k +: 8] = t_data[8*k +: 8];
                            m_known[t_addr][k] = 1'b1;
                        end
                    end
                end
                busy = 1'b0;
            end else if (busy) begin
                if (!held_ok()) begin
                    abort_at = cyc;
                    ack_at   = -1;
                    busy     = 1'b0;
                end
            end else if (read && write) begin
                abort_at = cyc;
            end else if (read || write) begin
                t_write = write;
                t_addr  = addr;
                t_data  = data_i;
                t_be    = be;
                ack_at  = cyc + 1 + MINL + (int'(m_lfsr) % (MAXL - MINL + 1));
                m_lfsr  = lfsr_step(m_lfsr);
                busy    = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("ack", ack, cyc == ack_at);
            check("abort", abort, cyc == abort_at);
            if (cyc == ack_at && !t_write) begin
                for (int k = 0; k < NB; k++) cmp_mask[8*k +: 8] = {8{m_known[t_addr][k]}};
                check("data_o", data_o & cmp_mask, m_mem[t_addr] & cmp_mask);
            end else begin
                check("data_o_idle", data_o, '0);
            end
        end
    end

    // ---------------- stimulus ----------------
    int lat_a [100];
    int lat_b [100];

    task automatic do_req(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [NB-1:0] b, output int lat, output logic [DW-1:0] rdata);
        bit done = 1'b0;
        @(negedge clk);
        read = !wr; write = wr; addr = a; data_i = d; be = b;
        lat = -1;
        rdata = '0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(posedge clk); #1;
            if (ack || abort) begin
                done  = 1'b1;
                lat   = ack ? n : -2;
                rdata = data_o;
                read  = 1'b0;
                write = 1'b0;
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL req_timeout: no ack or abort within 40 cycles, one required");
            read = 1'b0; write = 1'b0;
        end
        @(posedge clk);
    endtask

    task automatic random_phase(input int ncyc);
        bit active = 1'b0;
        int r;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (!active) begin
                r = int'($urandom_range(0, 9));
                read   = (r < 4) || (r == 8);
                write  = (r >= 4 && r < 9);
                addr   = AW'($urandom);
                data_i = DW'($urandom);
                be     = NB'($urandom);
                active = read || write;
            end else if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 3))
                    0:       addr   = addr ^ AW'(1);
                    1:       data_i = data_i ^ DW'(1);
                    2:       be     = be ^ NB'(1);
                    default: read   = !read;
                endcase
            end
            @(posedge clk); #1;
            if (ack || abort) begin
                read = 1'b0; write = 1'b0; active = 1'b0;
            end
        end
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic run_reads(input bit second);
        int l;
        logic [DW-1:0] rd;
        for (int i = 0; i < 100; i++) begin
            do_req(1'b0, AW'($urandom), '0, '0, l, rd);
            check("lat_in_range", (l >= MINL + 1 && l <= MAXL + 1), 1'b1);
            if (second) lat_b[i] = l;
            else        lat_a[i] = l;
        end
    endtask

    task automatic fx_req(input bit rd, input bit wr, input logic [4:0] a, input logic [7:0] d,
                          input int chg_at, input int rst_at,
                          output int ack_idx, output int abort_idx, output int ack_cnt,
                          output int abort_cnt, output logic [7:0] rdata,
                          output logic [7:0] data_seen);
        @(negedge clk);
        read_f = rd; write_f = wr; addr_f = a; data_if = d; be_f = 1'b1;
        ack_idx = -1; abort_idx = -1; ack_cnt = 0; abort_cnt = 0; rdata = '0; data_seen = '0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            data_seen = data_seen | data_of;
            if (ack_f) begin
                ack_cnt++;
                if (ack_idx < 0) ack_idx = n;
                rdata = data_of;
            end
            if (abort_f) begin
                abort_cnt++;
                if (abort_idx < 0) abort_idx = n;
            end
            if (ack_f || abort_f) begin
                read_f = 1'b0; write_f = 1'b0;
            end
            if (n == chg_at) addr_f = a + 5'd1;
            if (n == rst_at) begin
                read_f = 1'b0; write_f = 1'b0;
                rst_nf = 1'b0;
                #2 rst_nf = 1'b1;
            end
        end
    endtask

    initial begin
        int l, ai, bi, ac, bc;
        logic [DW-1:0] rd;
        logic [7:0] rf, seen;

        read = 0; write = 0; addr = '0; data_i = '0; be = '0;
        read_f = 0; write_f = 0; addr_f = '0; data_if = '0; be_f = '0;
        #1 rst_n = 1'b0; rst_nf = 1'b0;
        #20;
        check("rst_ack", ack, 1'b0);
        check("rst_abort", abort, 1'b0);
        check("rst_data_o", data_o, '0);
        check("rst_ack_f", ack_f, 1'b0);
        check("rst_abort_f", abort_f, 1'b0);
        check("rst_data_o_f", data_of, '0);
        @(negedge clk);
        rst_n = 1'b1; rst_nf = 1'b1; chk_on = 1'b1;

        for (int a = 0; a < (1 << AW); a++) begin
            do_req(1'b1, AW'(a), DW'($urandom), '1, l, rd);
        end

        // Byte-enable merge
        do_req(1'b1, AW'(3), 32'h11223344, 4'b1111, l, rd);
        do_req(1'b1, AW'(3), 32'hAABBCCDD, 4'b0101, l, rd);
        do_req(1'b0, AW'(3), '0, '0, l, rd);
        check("be_merge", rd, 32'h11BB33DD);

        random_phase(3000);

        // Latency range and reproducibility from SEED
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        run_reads(1'b0);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        run_reads(1'b1);
        check("lat_first_after_seed", lat_a[0], 9);
        check("lat_second_after_seed", lat_a[1], 10);
        for (int i = 0; i < 100; i++) check("lat_repeat", lat_b[i], lat_a[i]);

        // Fixed-latency instance, directed
        fx_req(1'b0, 1'b1, 5'd5, 8'hA5, -1, -1, ai, bi, ac, bc, rf, seen);
        check("fx_wr_ack_edge", ai, 4);
        check("fx_wr_ack_cnt", ac, 1);
        check("fx_wr_abort_cnt", bc, 0);
        check("fx_wr_data_o", rf, 8'h00);
        fx_req(1'b1, 1'b0, 5'd5, 8'h00, -1, -1, ai, bi, ac, bc, rf, seen);
        check("fx_rd_ack_edge", ai, 4);
        check("fx_rd_data", rf, 8'hA5);
        fx_req(1'b1, 1'b0, 5'd5, 8'h00, 2, -1, ai, bi, ac, bc, rf, seen);
        check("fx_chg_abort_edge", ai < 0 ? bi : -1, 3);
        check("fx_chg_ack_cnt", ac, 0);
        check("fx_chg_data_o", seen, 8'h00);
        fx_req(1'b1, 1'b1, 5'd5, 8'h00, -1, -1, ai, bi, ac, bc, rf, seen);
        check("fx_both_abort_edge", bi, 0);
        check("fx_both_ack_cnt", ac, 0);
        fx_req(1'b1, 1'b0, 5'd5, 8'h00, -1, -1, ai, bi, ac, bc, rf, seen);
        check("fx_after_both_data", rf, 8'hA5);
        fx_req(1'b0, 1'b1, 5'd7, 8'h3C, -1, -1, ai, bi, ac, bc, rf, seen);
        check("fx_w7_ack_cnt", ac, 1);
        fx_req(1'b0, 1'b1, 5'd7, 8'hFF, -1, 2, ai, bi, ac, bc, rf, seen);
        check("fx_rst_ack_cnt", ac, 0);
        check("fx_rst_abort_cnt", bc, 0);
        fx_req(1'b1, 1'b0, 5'd7, 8'h00, -1, -1, ai, bi, ac, bc, rf, seen);
        check("fx_rst_keeps_old", rf, 8'h3C);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
